// File: rtl/mem_arbiter_pkg.sv
// Shared types for the mem_arbiter block: data width, FSM state encoding and access opcode.
package mem_arbiter_pkg;

  localparam int unsigned XLEN = 32;

  // Legacy state encodings; the enum below is bound to them so both views agree.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MEM  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef enum logic [1:0] {
    StIdle = ST_IDLE,
    StMem  = ST_MEM,
    StResp = ST_RESP
  } mem_arb_state_t;

  typedef enum logic {
    OpRead  = 1'b0,
    OpWrite = 1'b1
  } opcode_t;

  // Value of last_gnt meaning "debug loader was granted last".
  localparam logic GNT_DEBUG = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: core and debug request ports, response and memory side.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic              c_req;
  logic              c_we;
  logic [XLEN-1:0]   c_addr;
  logic [XLEN-1:0]   c_wdata;
  logic [XLEN/8-1:0] c_be;
  logic              c_done;

  logic              d_req;
  logic              d_we;
  logic [XLEN-1:0]   d_addr;
  logic [XLEN-1:0]   d_wdata;
  logic [XLEN/8-1:0] d_be;
  logic              d_done;

  logic [XLEN-1:0]   rdata;
  logic              err;

  logic              mem_en;
  logic              mem_we;
  logic [XLEN-1:0]   mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN/8-1:0] mem_be;
  logic [XLEN-1:0]   mem_rdata;
  logic              mem_ready;

  // Arbiter view.
  modport slave (
    input  c_req, c_we, c_addr, c_wdata, c_be,
    input  d_req, d_we, d_addr, d_wdata, d_be,
    output c_done, d_done, rdata, err,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_rdata, mem_ready
  );

  // Requester / memory environment view.
  modport master (
    output c_req, c_we, c_addr, c_wdata, c_be,
    output d_req, d_we, d_addr, d_wdata, d_be,
    input  c_done, d_done, rdata, err,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_rdata, mem_ready
  );

endinterface

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Two-way round-robin pick: a sole requester wins; on a tie the one not granted last wins.
// Bit 0 is the core, bit 1 the debug loader; last_gnt=1 means debug won last.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic [1:0] gnt
);

  // Pass a single request through; break ties against the previous winner.
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = last_gnt ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Memory arbiter between a core port and a debug-loader port, one access at a time
// (IDLE -> MEM -> RESP). Define MEM_ARBITER_DEBUG_PORT_EN to enable the debug port with
// round-robin arbitration; without it the debug inputs are ignored and the core always wins.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  localparam int unsigned     CntW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  mem_arb_state_t    state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  opcode_t           op_q;
  logic [XLEN-1:0]   addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [XLEN/8-1:0] be_q;
  logic [XLEN-1:0]   rdata_q;
  logic              err_q;

  logic grant_valid;
  logic grant_dbg;
  logic grant_evt;
  logic timeout;

  assign grant_evt = (state_q == StIdle) && grant_valid;
  assign timeout   = (state_q == StMem) && !bus.mem_ready && (cnt_q == CntLast);

`ifdef MEM_ARBITER_DEBUG_PORT_EN
  logic [1:0] rr_gnt;
  logic       last_gnt_q;

  rr_arbiter2 u_rr_arbiter2 (
    .req      ({bus.d_req, bus.c_req}),
    .last_gnt (last_gnt_q),
    .gnt      (rr_gnt)
  );

  assign grant_valid = |rr_gnt;
  assign grant_dbg   = rr_gnt[1];

  // Record the winner on the grant edge; it also selects whose done fires in RESP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_gnt_q <= GNT_DEBUG;
    end else if (grant_evt) begin
      last_gnt_q <= grant_dbg;
    end
  end

  assign bus.c_done = (state_q == StResp) && (last_gnt_q != GNT_DEBUG);
  assign bus.d_done = (state_q == StResp) && (last_gnt_q == GNT_DEBUG);
`else
  logic unused_dbg;
  assign unused_dbg = ^{bus.d_req, bus.d_we, bus.d_addr, bus.d_wdata, bus.d_be};

  assign grant_valid = bus.c_req;
  assign grant_dbg   = 1'b0;
  assign bus.c_done  = (state_q == StResp);
  assign bus.d_done  = 1'b0;
`endif

  // Next-state and wait-counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (grant_valid) begin
          state_d = StMem;
          cnt_d   = '0;
        end
      end
      StMem: begin
        if (bus.mem_ready || timeout) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and wait counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Latch the winner's request so the memory side stays stable for all of MEM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q    <= OpRead;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else if (grant_evt) begin
      if (grant_dbg) begin
        op_q    <= opcode_t'(bus.d_we);
        addr_q  <= bus.d_addr;
        wdata_q <= bus.d_wdata;
        be_q    <= bus.d_be;
      end else begin
        op_q    <= opcode_t'(bus.c_we);
        addr_q  <= bus.c_addr;
        wdata_q <= bus.c_wdata;
        be_q    <= bus.c_be;
      end
    end
  end

  // Capture the response; rdata/err hold until the next completion or timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if ((state_q == StMem) && bus.mem_ready) begin
      rdata_q <= bus.mem_rdata;
      err_q   <= 1'b0;
    end else if (timeout) begin
      rdata_q <= '0;
      err_q   <= 1'b1;
    end
  end

  assign bus.mem_en    = (state_q == StMem);
  assign bus.mem_we    = (state_q == StMem) && (op_q == OpWrite);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_be    = be_q;
  assign bus.rdata     = rdata_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; debug-port expectations follow MEM_ARBITER_DEBUG_PORT_EN.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  mem_arbiter_if bus ();

  mem_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.c_req = 0; bus.c_we = 0; bus.c_addr = 0; bus.c_wdata = 0; bus.c_be = 0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0; bus.d_be = 0;
    bus.mem_ready = 0; bus.mem_rdata = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    repeat (2) step();
    checks++;
    if ({bus.mem_en, bus.mem_we, bus.c_done, bus.d_done, bus.err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 00000",
               {bus.mem_en, bus.mem_we, bus.c_done, bus.d_done, bus.err});
    end
    checks++;
    if (bus.rdata !== 32'h0) begin
      errors++; $display("FAIL reset_rdata: got %h want 0", bus.rdata);
    end
    checks++;
    if ({bus.mem_addr, bus.mem_wdata, bus.mem_be} !== 68'h0) begin
      errors++; $display("FAIL reset_mem_bus: got %h %h %h want 0", bus.mem_addr,
                         bus.mem_wdata, bus.mem_be);
    end
    reset = 0;
    step();
    checks++;
    if (bus.mem_en !== 1'b0) begin
      errors++; $display("FAIL idle_no_req: got mem_en=%b want 0", bus.mem_en);
    end
  endtask

  task automatic test_core_read();
    bus.c_req = 1; bus.c_we = 0; bus.c_addr = 32'h100; bus.c_be = 4'hF;
    bus.mem_ready = 0; bus.mem_rdata = 32'h0BAD0BAD;
    step();
    checks++;
    if ({bus.mem_en, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b0, 32'h100}) begin
      errors++; $display("FAIL read_mem1: got en=%b we=%b addr=%h want 1 0 100",
                         bus.mem_en, bus.mem_we, bus.mem_addr);
    end
    step();
    checks++;
    if ({bus.mem_en, bus.c_done} !== 2'b10) begin
      errors++; $display("FAIL read_mem2: got en=%b done=%b want 1 0", bus.mem_en, bus.c_done);
    end
    bus.mem_ready = 1; bus.mem_rdata = 32'hDEADBEEF;
    step();
    checks++;
    if ({bus.c_done, bus.d_done, bus.mem_en} !== 3'b100) begin
      errors++; $display("FAIL read_done: got c=%b d=%b en=%b want 1 0 0",
                         bus.c_done, bus.d_done, bus.mem_en);
    end
    checks++;
    if ({bus.rdata, bus.err} !== {32'hDEADBEEF, 1'b0}) begin
      errors++; $display("FAIL read_data: got %h err=%b want deadbeef 0", bus.rdata, bus.err);
    end
    bus.c_req = 0; bus.mem_ready = 0; bus.mem_rdata = 0;
    step();
    checks++;
    if (bus.c_done !== 1'b0) begin
      errors++; $display("FAIL read_done_pulse: got %b want 0", bus.c_done);
    end
    checks++;
    if (bus.rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL read_hold: got %h want deadbeef", bus.rdata);
    end
  endtask

  task automatic test_min_latency_write();
    bus.c_req = 1; bus.c_we = 1; bus.c_addr = 32'h104; bus.c_wdata = 32'hCAFEF00D;
    bus.c_be = 4'b1100; bus.mem_ready = 1; bus.mem_rdata = 32'hA5A5A5A5;
    step();
    checks++;
    if ({bus.mem_en, bus.mem_we, bus.mem_wdata, bus.mem_be} !==
        {1'b1, 1'b1, 32'hCAFEF00D, 4'b1100}) begin
      errors++; $display("FAIL wr_mem: got en=%b we=%b wd=%h be=%b want 1 1 cafef00d 1100",
                         bus.mem_en, bus.mem_we, bus.mem_wdata, bus.mem_be);
    end
    step();
    checks++;
    if (bus.c_done !== 1'b1) begin
      errors++; $display("FAIL wr_latency3: got c_done=%b want 1", bus.c_done);
    end
    checks++;
    if ({bus.rdata, bus.err} !== {32'hA5A5A5A5, 1'b0}) begin
      errors++; $display("FAIL wr_rdata: got %h err=%b want a5a5a5a5 0", bus.rdata, bus.err);
    end
    bus.c_req = 0; bus.mem_ready = 0;
    step();
    checks++;
    if ({bus.mem_we, bus.c_done} !== 2'b00) begin
      errors++; $display("FAIL wr_after: got we=%b done=%b want 0 0", bus.mem_we, bus.c_done);
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    bus.c_req = 1; bus.c_we = 0; bus.c_addr = 32'h108; bus.mem_ready = 0;
    step();
    step();
    checks++;
    if (bus.mem_en !== 1'b1) begin
      errors++; $display("FAIL rst_mid_pre: got mem_en=%b want 1", bus.mem_en);
    end
    reset = 1;
    #1;
    checks++;
    if ({bus.mem_en, bus.c_done, bus.rdata} !== 34'h0) begin
      errors++; $display("FAIL rst_mid_async: got en=%b done=%b rdata=%h want 0 0 0",
                         bus.mem_en, bus.c_done, bus.rdata);
    end
    bus.c_req = 0;
    step();
    reset = 0;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (bus.mem_en || bus.c_done || bus.d_done) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL rst_mid_no_done: got %0d active cycles want 0", bad);
    end
    bus.c_req = 1; bus.c_addr = 32'h10C; bus.mem_ready = 1;
    step();
    checks++;
    if ({bus.mem_en, bus.mem_addr} !== {1'b1, 32'h10C}) begin
      errors++; $display("FAIL rst_mid_idle: got en=%b addr=%h want 1 10c",
                         bus.mem_en, bus.mem_addr);
    end
    step();
    bus.c_req = 0; bus.mem_ready = 0;
    step();
  endtask

  task automatic test_back_to_back();
    bus.c_req = 1; bus.c_we = 0; bus.c_addr = 32'h110;
    bus.mem_ready = 1; bus.mem_rdata = 32'h11111111;
    step();
    step();
    checks++;
    if ({bus.c_done, bus.rdata} !== {1'b1, 32'h11111111}) begin
      errors++; $display("FAIL b2b_first: got done=%b rdata=%h want 1 11111111",
                         bus.c_done, bus.rdata);
    end
    bus.c_addr = 32'h114; bus.mem_rdata = 32'h22222222;
    step();
    checks++;
    if ({bus.mem_en, bus.c_done} !== 2'b00) begin
      errors++; $display("FAIL b2b_idle: got en=%b done=%b want 0 0", bus.mem_en, bus.c_done);
    end
    step();
    checks++;
    if ({bus.mem_en, bus.mem_addr} !== {1'b1, 32'h114}) begin
      errors++; $display("FAIL b2b_second: got en=%b addr=%h want 1 114",
                         bus.mem_en, bus.mem_addr);
    end
    bus.c_req = 0; bus.mem_ready = 0;
    step();
    checks++;
    if (bus.mem_en !== 1'b1) begin
      errors++; $display("FAIL b2b_no_abort: got mem_en=%b want 1", bus.mem_en);
    end
    bus.mem_ready = 1;
    step();
    checks++;
    if ({bus.c_done, bus.rdata} !== {1'b1, 32'h22222222}) begin
      errors++; $display("FAIL b2b_second_done: got done=%b rdata=%h want 1 22222222",
                         bus.c_done, bus.rdata);
    end
    bus.mem_ready = 0;
    step();
    step();
    checks++;
    if (bus.mem_en !== 1'b0) begin
      errors++; $display("FAIL b2b_stop: got mem_en=%b want 0", bus.mem_en);
    end
  endtask

  task automatic test_timeout();
    int  mem_cycles;
    bit  done_seen;
    logic [31:0] got_rdata;
    logic        got_err;
    mem_cycles = 0; done_seen = 0; got_rdata = 'x; got_err = 'x;
    bus.c_req = 1; bus.c_we = 0; bus.c_addr = 32'h300; bus.mem_ready = 0;
    for (int i = 0; i < 40 && !done_seen; i++) begin
      step();
      if (bus.mem_en) mem_cycles++;
      if (bus.c_done) begin
        done_seen = 1; got_rdata = bus.rdata; got_err = bus.err;
      end
    end
    bus.c_req = 0;
    checks++;
    if (!done_seen) begin
      errors++; $display("FAIL tmo_done: got no c_done want c_done");
    end
    checks++;
    if (mem_cycles != 16) begin
      errors++; $display("FAIL tmo_cycles: got %0d want 16", mem_cycles);
    end
    checks++;
    if ({got_err, got_rdata} !== {1'b1, 32'h0}) begin
      errors++; $display("FAIL tmo_resp: got err=%b rdata=%h want 1 0", got_err, got_rdata);
    end
    step();
    checks++;
    if (bus.err !== 1'b1) begin
      errors++; $display("FAIL tmo_err_hold: got %b want 1", bus.err);
    end
  endtask

  task automatic test_debug_write();
`ifdef MEM_ARBITER_DEBUG_PORT_EN
    int bad;
    int early;
    bad = 0; early = 0;
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h200; bus.d_wdata = 32'h12345678;
    bus.d_be = 4'b0011; bus.mem_ready = 0;
    step();
    // Scramble the source: the memory side must keep the latched values.
    bus.d_addr = 32'hFFFFFFFC; bus.d_wdata = 32'h0; bus.d_be = 4'hF;
    for (int i = 0; i < 3; i++) begin
      if ({bus.mem_en, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata} !==
          {1'b1, 1'b1, 4'b0011, 32'h200, 32'h12345678}) bad++;
      if (bus.c_done || bus.d_done) early++;
      if (i == 2) bus.mem_ready = 1;
      step();
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL dbg_stable: got %0d unstable MEM cycles want 0", bad);
    end
    checks++;
    if (early != 0) begin
      errors++; $display("FAIL dbg_early_done: got %0d want 0", early);
    end
    checks++;
    if ({bus.d_done, bus.c_done} !== 2'b10) begin
      errors++; $display("FAIL dbg_done: got d=%b c=%b want 1 0", bus.d_done, bus.c_done);
    end
    bus.d_req = 0; bus.mem_ready = 0;
    step();
    checks++;
    if ({bus.d_done, bus.mem_we} !== 2'b00) begin
      errors++; $display("FAIL dbg_after: got d=%b we=%b want 0 0", bus.d_done, bus.mem_we);
    end
`else
    int bad;
    bad = 0;
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h200; bus.d_wdata = 32'h12345678;
    bus.d_be = 4'b0011; bus.mem_ready = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (bus.mem_en || bus.d_done || bus.c_done) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL dbg_ignored: got %0d active cycles want 0", bad);
    end
    checks++;
    if (bus.d_done !== 1'b0) begin
      errors++; $display("FAIL dbg_done_tied: got %b want 0", bus.d_done);
    end
    bus.d_req = 0; bus.mem_ready = 0;
    step();
`endif
  endtask

  task automatic test_round_robin();
    logic [3:0]  order;
    logic [3:0]  exp_order;
    logic [31:0] last_addr;
    int n;
    int addr_bad;
`ifdef MEM_ARBITER_DEBUG_PORT_EN
    exp_order = 4'b1010;
`else
    exp_order = 4'b0000;
`endif
    order = 0; n = 0; addr_bad = 0; last_addr = 0;
    reset = 1;
    step();
    reset = 0;
    bus.c_req = 1; bus.c_we = 0; bus.c_addr = 32'h400;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h500;
    bus.mem_ready = 1; bus.mem_rdata = 32'h5A5A5A5A;
    for (int i = 0; i < 40 && n < 4; i++) begin
      step();
      if (bus.mem_en) last_addr = bus.mem_addr;
      if (bus.c_done || bus.d_done) begin
        if (bus.c_done && bus.d_done) addr_bad++;
        if (last_addr !== (bus.d_done ? 32'h500 : 32'h400)) addr_bad++;
        order[n] = bus.d_done;
        n++;
      end
    end
    bus.c_req = 0; bus.d_req = 0; bus.mem_ready = 0;
    checks++;
    if (n != 4) begin
      errors++; $display("FAIL rr_count: got %0d transactions want 4", n);
    end
    checks++;
    if (order !== exp_order) begin
      errors++; $display("FAIL rr_order: got %b want %b (bit0 first, 1=debug)", order, exp_order);
    end
    checks++;
    if (addr_bad != 0) begin
      errors++; $display("FAIL rr_addr: got %0d bad grants want 0", addr_bad);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_core_read();
    test_min_latency_write();
    test_reset_mid();
    test_back_to_back();
    test_timeout();
    test_debug_write();
    test_round_robin();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 TIMEOUT_CYCLES, 16, max MEM-state cycles waiting for mem_ready before an error response.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 c_req  input  1  core access request, held until c_done.
REQ-005 c_we  input  1  core write (1) / read (0).
REQ-006 c_addr  input  32  core byte address.
REQ-007 c_wdata  input  32  core store data.
REQ-008 c_be  input  4  core byte enables.
REQ-009 c_done  output  1  one-cycle core completion strobe.
REQ-010 d_req  input  1  debug-loader access request, held until d_done.
REQ-011 d_we  input  1  debug write / read.
REQ-012 d_addr  input  32  debug byte address.
REQ-013 d_wdata  input  32  debug store data.
REQ-014 d_be  input  4  debug byte enables.
REQ-015 d_done  output  1  one-cycle debug completion strobe.
REQ-016 rdata  output  32  read data, valid while c_done or d_done is high.
REQ-017 err  output  1  timeout flag, valid while c_done or d_done is high.
REQ-018 mem_en  output  1  memory access enable.
REQ-019 mem_we  output  1  memory write enable.
REQ-020 mem_addr  output  32  memory address.
REQ-021 mem_wdata  output  32  memory write data.
REQ-022 mem_be  output  4  memory byte enables.
REQ-023 mem_rdata  input  32  memory read data, valid when mem_ready is high.
REQ-024 mem_ready  input  1  memory completion, sampled only in MEM.

Function
REQ-025 FSM states SHALL be IDLE, MEM and RESP, with IDLE->MEM on any request, MEM->RESP on mem_ready or timeout, and RESP->IDLE unconditionally.
REQ-026 In IDLE, the block SHALL grant a sole requester; on simultaneous requests it SHALL grant the requester not granted last (round-robin last_gnt bit).
REQ-027 On the grant edge, the winner's we/addr/wdata/be SHALL be latched; mem_* outputs SHALL be driven from the latches, stable for the whole of MEM.
REQ-028 mem_en SHALL be high only in MEM; mem_we SHALL equal latched we in MEM and be 0 otherwise.
REQ-029 On mem_ready in MEM, mem_rdata SHALL be captured into rdata with err=0 (rdata SHALL be captured for writes too).
REQ-030 The wait counter SHALL clear on MEM entry; if mem_ready is not seen by MEM cycle TIMEOUT_CYCLES, the block SHALL enter RESP with err=1 and rdata=0.
REQ-031 In RESP, exactly the granted requester's done SHALL be high for exactly one cycle.
REQ-032 Minimum latency SHALL be 3 cycles from request to done (IDLE, MEM with mem_ready, RESP).
REQ-033 Deasserting req mid-transaction SHALL NOT abort it; req still high in the IDLE after done SHALL start a new transaction.
REQ-034 rdata and err SHALL hold their values until the next capture.

Reset
REQ-035 Reset SHALL force IDLE, clear the counter and latches, set all outputs to 0, and set last_gnt=debug so that the core wins the first tie.
REQ-036 Reset mid-transaction SHALL drop mem_en immediately and SHALL issue no done, so the requester must reissue.

Configuration
REQ-037 With MEM_ARBITER_DEBUG_PORT_EN defined, the block SHALL implement two-way round-robin arbitration as specified above.
REQ-038 Without MEM_ARBITER_DEBUG_PORT_EN, d_* inputs SHALL be ignored, d_done SHALL be tied to 0, the core SHALL always be granted, and no last_gnt register SHALL exist.

Structure
REQ-039 The state enum mem_arb_state_t and the XLEN=32 constant SHALL live in the shared types header with opcode_t.
REQ-040 The two-way round-robin pick SHALL be the sub-module rr_arbiter2 (inputs req[1:0] and last_gnt; output gnt[1:0]).

Verification
REQ-041 Core read of 0x100 with mem_ready after 2 cycles and mem_rdata=0xDEADBEEF -> c_done=1 for one cycle, rdata=0xDEADBEEF, err=0.
REQ-042 Debug write to 0x200 with wdata=0x12345678 and be=0b0011 -> mem_we=1, mem_be=0b0011 stable throughout MEM, then d_done, with c_done remaining 0.
REQ-043 c_req and d_req both held high for 4 transactions out of reset -> grant order core, debug, core, debug.
REQ-044 mem_ready held at 0 -> done after 16 MEM cycles with err=1 and rdata=0.
REQ-045 Reset asserted on the 2nd MEM cycle -> mem_en=0 immediately, no done, and the FSM in IDLE after reset release.
